// File: rtl/kmkz_dbus_arbiter.sv
// Two-master AHB-Lite data-bus arbiter: core (m0) and debug/DMA (m1) share one slave path.
// Define KMKZ_DBUS_RR_EN for round-robin arbitration; default is fixed priority m1 > m0.
module kmkz_dbus_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_haddr_i,
  input  logic [1:0]  m0_htrans_i,
  input  logic        m0_hwrite_i,
  input  logic [2:0]  m0_hsize_i,
  input  logic [3:0]  m0_hprot_i,
  input  logic [31:0] m0_hwdata_i,
  input  logic [31:0] m1_haddr_i,
  input  logic [1:0]  m1_htrans_i,
  input  logic        m1_hwrite_i,
  input  logic [2:0]  m1_hsize_i,
  input  logic [3:0]  m1_hprot_i,
  input  logic [31:0] m1_hwdata_i,
  output logic        m0_hready_o,
  output logic        m1_hready_o,
  output logic        m0_hresp_o,
  output logic        m1_hresp_o,
  output logic [31:0] HRDATA_o,
  output logic [31:0] HADDR,
  output logic [2:0]  HSIZE,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  typedef enum logic [1:0] {StIdle, StDataM0, StDataM1} own_e;

  own_e        own_q;
  logic        gnt;
  logic        gnt_q;
  logic [31:0] wdata_q;
  logic        req0;
  logic        req1;
  logic        accept;
  logic        gnt_write;
  logic [31:0] gnt_wdata;

  assign req0 = m0_htrans_i[1];
  assign req1 = m1_htrans_i[1];

`ifdef KMKZ_DBUS_RR_EN
  logic last_q;
`endif

  // Address phase is frozen while the slave stalls; with no request we park on the last owner.
  always_comb begin
    gnt = gnt_q;
    if (HREADY) begin
      if (req0 && req1) begin
`ifdef KMKZ_DBUS_RR_EN
        gnt = ~last_q;
`else
        gnt = 1'b1;
`endif
      end else if (req1) begin
        gnt = 1'b1;
      end else if (req0) begin
        gnt = 1'b0;
      end
    end
  end

  assign accept    = HREADY & (gnt ? req1 : req0);
  assign gnt_write = gnt ? m1_hwrite_i : m0_hwrite_i;
  assign gnt_wdata = gnt ? m1_hwdata_i : m0_hwdata_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_q   <= 1'b0;
      own_q   <= StIdle;
      wdata_q <= 32'h0;
    end else if (HREADY) begin
      gnt_q <= gnt;
      if (accept) begin
        own_q <= gnt ? StDataM1 : StDataM0;
        if (gnt_write) begin
          wdata_q <= gnt_wdata;
        end
      end else begin
        own_q <= StIdle;
      end
    end
  end

`ifdef KMKZ_DBUS_RR_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= 1'b0;
    end else if (accept) begin
      last_q <= gnt;
    end
  end
`endif

  assign HADDR     = gnt ? m1_haddr_i  : m0_haddr_i;
  assign HTRANS    = gnt ? m1_htrans_i : m0_htrans_i;
  assign HWRITE    = gnt ? m1_hwrite_i : m0_hwrite_i;
  assign HSIZE     = gnt ? m1_hsize_i  : m0_hsize_i;
  assign HPROT     = gnt ? m1_hprot_i  : m0_hprot_i;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = wdata_q;
  assign HRDATA_o  = HRDATA;

  // A requesting master that lost the address phase stalls with its address held.
  assign m0_hready_o = (req0 && gnt)  ? 1'b0 : HREADY;
  assign m1_hready_o = (req1 && !gnt) ? 1'b0 : HREADY;

  assign m0_hresp_o = (own_q == StDataM0) ? HRESP : 1'b0;
  assign m1_hresp_o = (own_q == StDataM1) ? HRESP : 1'b0;

endmodule

// File: tb/tb_kmkz_dbus_arbiter.sv
// Bench for kmkz_dbus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_kmkz_dbus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] HRDATA_o, HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;

  int total = 0;
  int bad   = 0;

  // Reference model: current owner of the address phase, data-phase owner (0 none, 1 m0,
  // 2 m1), write data on the bus and the last accepted master.
  int          mgnt, mown, mlast;
  logic [31:0] mwdata;

  always #5 clk_i = ~clk_i;

  kmkz_dbus_arbiter dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m0_haddr_i (m0_haddr),
    .m0_htrans_i(m0_htrans),
    .m0_hwrite_i(m0_hwrite),
    .m0_hsize_i (m0_hsize),
    .m0_hprot_i (m0_hprot),
    .m0_hwdata_i(m0_hwdata),
    .m1_haddr_i (m1_haddr),
    .m1_htrans_i(m1_htrans),
    .m1_hwrite_i(m1_hwrite),
    .m1_hsize_i (m1_hsize),
    .m1_hprot_i (m1_hprot),
    .m1_hwdata_i(m1_hwdata),
    .m0_hready_o(m0_hready),
    .m1_hready_o(m1_hready),
    .m0_hresp_o (m0_hresp),
    .m1_hresp_o (m1_hresp),
    .HRDATA_o   (HRDATA_o),
    .HADDR      (HADDR),
    .HSIZE      (HSIZE),
    .HPROT      (HPROT),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HBURST     (HBURST),
    .HMASTLOCK  (HMASTLOCK),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA)
  );

  logic [113:0] act_vec;
  assign act_vec = {HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, m0_hready, m1_hready,
                    m0_hresp, m1_hresp, HRDATA_o, HBURST, HMASTLOCK};

  function automatic int arb();
    bit r0, r1;
    r0 = m0_htrans[1];
    r1 = m1_htrans[1];
    if (!HREADY) return mgnt;
    if (r0 && r1) begin
`ifdef KMKZ_DBUS_RR_EN
      return 1 - mlast;
`else
      return 1;
`endif
    end
    if (r1) return 1;
    if (r0) return 0;
    return mgnt;
  endfunction

  function automatic logic [113:0] exp_vec();
    int g;
    bit r0, r1;
    g  = arb();
    r0 = m0_htrans[1];
    r1 = m1_htrans[1];
    return {(g == 1) ? m1_haddr : m0_haddr, (g == 1) ? m1_htrans : m0_htrans,
            (g == 1) ? m1_hwrite : m0_hwrite, (g == 1) ? m1_hsize : m0_hsize,
            (g == 1) ? m1_hprot : m0_hprot, mwdata,
            (r0 && g != 0) ? 1'b0 : HREADY, (r1 && g != 1) ? 1'b0 : HREADY,
            (mown == 1) ? HRESP : 1'b0, (mown == 2) ? HRESP : 1'b0, HRDATA, 3'b000, 1'b0};
  endfunction

  task automatic model_reset();
    mgnt = 0; mown = 0; mlast = 0; mwdata = 32'h0;
  endtask

  task automatic model_clock();
    int g;
    bit acc;
    g   = arb();
    acc = HREADY && ((g == 1) ? m1_htrans[1] : m0_htrans[1]);
    if (HREADY) begin
      if (acc) begin
        mown  = g + 1;
        mlast = g;
        if ((g == 1) ? m1_hwrite : m0_hwrite) mwdata = (g == 1) ? m1_hwdata : m0_hwdata;
      end else begin
        mown = 0;
      end
      mgnt = g;
    end
  endtask

  task automatic adv();
    if (rst_i) model_clock();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_masters();
    m0_htrans = 2'b00; m1_htrans = 2'b00;
    m0_hwrite = 1'b0;  m1_hwrite = 1'b0;
  endtask

  task automatic m0_req(input logic [31:0] a, input logic w, input logic [31:0] d);
    m0_haddr = a; m0_htrans = 2'b10; m0_hwrite = w; m0_hwdata = d;
  endtask

  task automatic m1_req(input logic [31:0] a, input logic w, input logic [31:0] d);
    m1_haddr = a; m1_htrans = 2'b10; m1_hwrite = w; m1_hwdata = d;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    idle_masters();
    m0_haddr = 32'h0000_0abc; m1_haddr = 32'h0000_0def;
    m0_hwdata = 32'h1; m1_hwdata = 32'h2;
    m0_hsize = 3'd2; m1_hsize = 3'd2; m0_hprot = 4'h3; m1_hprot = 4'h3;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hcafe_0001;
    #2;
    model_reset();
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL reset_htrans got=%h want=0", HTRANS); end
    total++; if (HADDR !== 32'h0000_0abc) begin bad++; $display("FAIL reset_haddr got=%h want=abc", HADDR); end
    total++; if (HWDATA !== 32'h0) begin bad++; $display("FAIL reset_hwdata got=%h want=0", HWDATA); end
    total++; if (m0_hready !== 1'b1 || m1_hready !== 1'b1) begin bad++; $display("FAIL reset_hready got=%b%b want=11", m0_hready, m1_hready); end
    total++; if (m0_hresp !== 1'b0 || m1_hresp !== 1'b0) begin bad++; $display("FAIL reset_hresp got=%b%b want=00", m0_hresp, m1_hresp); end
    total++; if (HBURST !== 3'b000 || HMASTLOCK !== 1'b0) begin bad++; $display("FAIL reset_const got=%b/%b want=000/0", HBURST, HMASTLOCK); end
    total++; if (HRDATA_o !== 32'hcafe_0001) begin bad++; $display("FAIL reset_hrdata got=%h want=cafe0001", HRDATA_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    adv();
  endtask

  task automatic test_single();
    m0_req(32'h0000_1000, 1'b0, 32'h0);
    @(negedge clk_i);
    total++; if (HADDR !== 32'h0000_1000) begin bad++; $display("FAIL single_rd_addr got=%h want=1000", HADDR); end
    total++; if (m0_hready !== 1'b1) begin bad++; $display("FAIL single_rd_rdy got=%b want=1", m0_hready); end
    adv();
    m0_req(32'h0000_1004, 1'b1, 32'hdead_beef);
    @(negedge clk_i);
    total++; if (HADDR !== 32'h0000_1004 || HWRITE !== 1'b1) begin bad++; $display("FAIL single_wr_addr got=%h/%b want=1004/1", HADDR, HWRITE); end
    total++; if (m0_hready !== 1'b1) begin bad++; $display("FAIL single_wr_rdy got=%b want=1", m0_hready); end
    adv();
    idle_masters();
    m0_hwdata = 32'h0;
    @(negedge clk_i);
    total++; if (HWDATA !== 32'hdead_beef) begin bad++; $display("FAIL single_hwdata got=%h want=deadbeef", HWDATA); end
    total++; if (m0_hready !== 1'b1) begin bad++; $display("FAIL single_dp_rdy got=%b want=1", m0_hready); end
    adv();
  endtask

  task automatic test_contention();
    m0_req(32'h0000_2000, 1'b0, 32'h0);
    m1_req(32'h0000_3000, 1'b0, 32'h0);
    @(negedge clk_i);
    total++; if (HADDR !== 32'h0000_3000) begin bad++; $display("FAIL cont_win_addr got=%h want=3000", HADDR); end
    total++; if (m0_hready !== 1'b0 || m1_hready !== 1'b1) begin bad++; $display("FAIL cont_rdy got=%b%b want=01", m0_hready, m1_hready); end
    adv();
    m1_htrans = 2'b00;
    @(negedge clk_i);
    total++; if (HADDR !== 32'h0000_2000 || HTRANS !== 2'b10) begin bad++; $display("FAIL cont_lose_addr got=%h/%b want=2000/10", HADDR, HTRANS); end
    total++; if (m0_hready !== 1'b1) begin bad++; $display("FAIL cont_lose_rdy got=%b want=1", m0_hready); end
    adv();
    idle_masters();
    adv();
  endtask

  task automatic test_wait_states();
    m1_req(32'h0000_4000, 1'b1, 32'h1234_5678);
    @(negedge clk_i);
    total++; if (HADDR !== 32'h0000_4000) begin bad++; $display("FAIL wait_addr0 got=%h want=4000", HADDR); end
    adv();
    m1_htrans = 2'b00; m1_hwrite = 1'b0; m1_hwdata = 32'hffff_ffff;
    m0_req(32'h0000_5000, 1'b0, 32'h0);
    HREADY = 1'b0; HRESP = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      total++; if (HWDATA !== 32'h1234_5678) begin bad++; $display("FAIL wait_hwdata[%0d] got=%h want=12345678", i, HWDATA); end
      total++; if (HADDR !== 32'h0000_4000) begin bad++; $display("FAIL wait_haddr[%0d] got=%h want=4000", i, HADDR); end
      total++; if (m1_hresp !== 1'b1 || m0_hresp !== 1'b0) begin bad++; $display("FAIL wait_own[%0d] got=%b%b want=01", i, m0_hresp, m1_hresp); end
      total++; if (m0_hready !== 1'b0) begin bad++; $display("FAIL wait_m0rdy[%0d] got=%b want=0", i, m0_hready); end
      adv();
    end
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge clk_i);
    total++; if (HADDR !== 32'h0000_5000 || m0_hready !== 1'b1) begin bad++; $display("FAIL wait_release got=%h/%b want=5000/1", HADDR, m0_hready); end
    adv();
    idle_masters();
    adv();
  endtask

  task automatic test_error();
    m0_req(32'h0000_9000, 1'b0, 32'h0);
    adv();
    idle_masters();
    HRESP = 1'b1;
    @(negedge clk_i);
    total++; if (m0_hresp !== 1'b1 || m1_hresp !== 1'b0) begin bad++; $display("FAIL err_route got=%b%b want=10", m0_hresp, m1_hresp); end
    adv();
    HRESP = 1'b0;
  endtask

  task automatic test_arbitration_seq();
    logic [31:0] want;
    m0_req(32'h0000_6000, 1'b0, 32'h0);
    m1_req(32'h0000_7000, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
`ifdef KMKZ_DBUS_RR_EN
      want = (i % 2 == 0) ? 32'h0000_7000 : 32'h0000_6000;
`else
      want = 32'h0000_7000;
`endif
      @(negedge clk_i);
      total++; if (HADDR !== want) begin bad++; $display("FAIL arb_seq[%0d] got=%h want=%h", i, HADDR, want); end
      adv();
    end
    idle_masters();
    adv();
  endtask

  task automatic test_reset_mid();
    m1_req(32'h0000_b000, 1'b1, 32'ha5a5_a5a5);
    adv();
    idle_masters();
    HREADY = 1'b0; HRESP = 1'b1;
    @(negedge clk_i);
    total++; if (m1_hresp !== 1'b1 || HWDATA !== 32'ha5a5_a5a5) begin bad++; $display("FAIL rstmid_pre got=%b/%h want=1/a5a5a5a5", m1_hresp, HWDATA); end
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    model_reset();
    total++; if (HWDATA !== 32'h0) begin bad++; $display("FAIL rstmid_hwdata got=%h want=0", HWDATA); end
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL rstmid_htrans got=%b want=00", HTRANS); end
    total++; if (m1_hresp !== 1'b0 || m0_hresp !== 1'b0) begin bad++; $display("FAIL rstmid_hresp got=%b%b want=00", m0_hresp, m1_hresp); end
    @(negedge clk_i);
    rst_i = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
    adv();
    m0_req(32'h0000_8000, 1'b0, 32'h0);
    @(negedge clk_i);
    total++; if (HADDR !== 32'h0000_8000 || HTRANS !== 2'b10 || m0_hready !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%h/%b/%b want=8000/10/1", HADDR, HTRANS, m0_hready); end
    adv();
    idle_masters();
    HRESP = 1'b1;
    @(negedge clk_i);
    total++; if (m0_hresp !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%b want=1", m0_hresp); end
    adv();
    HRESP = 1'b0;
  endtask

  task automatic test_random();
    logic [113:0] want;
    for (int i = 0; i < 400; i++) begin
      m0_haddr  = $urandom; m1_haddr  = $urandom;
      m0_htrans = ($urandom_range(0, 2) != 0) ? 2'b10 : 2'b00;
      m1_htrans = ($urandom_range(0, 2) != 0) ? 2'b10 : 2'b00;
      m0_hwrite = 1'($urandom); m1_hwrite = 1'($urandom);
      m0_hsize  = 3'($urandom); m1_hsize  = 3'($urandom);
      m0_hprot  = 4'($urandom); m1_hprot  = 4'($urandom);
      m0_hwdata = $urandom; m1_hwdata = $urandom;
      HREADY = ($urandom_range(0, 3) != 0);
      HRESP  = ($urandom_range(0, 5) == 0);
      HRDATA = $urandom;
      @(negedge clk_i);
      want = exp_vec();
      total++;
      if (act_vec !== want) begin
        bad++;
        $display("FAIL random[%0d] got=%h want=%h", i, act_vec, want);
      end
      adv();
    end
    idle_masters();
    HREADY = 1'b1; HRESP = 1'b0;
    adv();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wait_states();
    test_error();
    test_arbitration_seq();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
